// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with a valid/ready handshake and a
// two-entry skid buffer (main + skid). Upstream ready comes from registered
// state only, so no combinational path runs from out_ready to in_ready.
// Also provides flush (bubble), hold (freeze), optional zeroing of out_data
// while empty, and a saturating count of upstream-stall cycles.
module pipe_stage_skid #(
  parameter int DATA_W        = 64,
  parameter int ZERO_ON_EMPTY = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                in_fire;
  logic                out_fire;
  logic                up_stall;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Handshake outputs depend only on registered state and hold.
  always_comb begin
    in_ready  = !hold && (state_q != FULL);
    out_valid = !hold && (state_q != EMPTY);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    up_stall  = in_valid && !in_ready;
  end

  // Presented payload and occupancy decode.
  always_comb begin
    out_data = main_q;
    if ((state_q == EMPTY) && (ZERO_ON_EMPTY != 0)) begin
      out_data = '0;
    end
    case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
    stall_cnt = stall_q;
  end

  // Next-state and storage update: flush beats hold beats normal transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A beat leaving this cycle counts as delivered; an arriving one is dropped.
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else if (!hold) begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d  = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Stall counter counts every cycle an offered beat is refused, hold included.
  always_comb begin
    stall_d = stall_q;
    if (up_stall) begin
      stall_d = sat_inc(stall_q);
    end
  end

  // State, storage and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: scoreboard on a default instance plus directed
// checks on a second instance (ZERO_ON_EMPTY = 0, CNT_W = 4).
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance signals
  logic        reset, flush, hold, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  // Second instance signals
  logic        reset2, flush2, hold2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0]  in_data2, out_data2;
  logic [1:0]  occupancy2;
  logic [3:0]  stall_cnt2;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  pipe_stage_skid dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(8), .ZERO_ON_EMPTY(0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .flush(flush2), .hold(hold2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every beat that will be taken at the next edge is popped and compared.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got=%0h expected=none", out_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL beat_data: got=%0h expected=%0h", out_data, e);
        end
      end
    end
  end

  initial begin
    reset = 1; flush = 0; hold = 0; in_valid = 0; out_ready = 0; in_data = '0;
    reset2 = 1; flush2 = 0; hold2 = 0; in_valid2 = 0; out_ready2 = 0; in_data2 = '0;
    step(); step();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall", stall_cnt, 0);
    step();
    reset = 0; reset2 = 0;

    // Stream 0x10..0x12 at full throughput
    out_ready = 1;
    exp_q.push_back(64'h10); exp_q.push_back(64'h11); exp_q.push_back(64'h12);
    in_valid = 1; in_data = 64'h10;
    @(negedge clk); check("stream_pre_out_valid", out_valid, 0);
    step(); in_data = 64'h11;
    @(negedge clk); check("stream_latency_out_valid", out_valid, 1);
    check("stream_occ1", occupancy, 1);
    step(); in_data = 64'h12;
    @(negedge clk); check("stream_in_ready", in_ready, 1);
    check("stream_occ2", occupancy, 1);
    step(); in_valid = 0;
    @(negedge clk); check("stream_occ3", occupancy, 1);
    step();
    @(negedge clk); check("stream_drained_occ", occupancy, 0);
    check("stream_drained_data", out_data, 0);

    // Backpressure into the skid entry
    step(); out_ready = 0;
    exp_q.push_back(64'hA0); exp_q.push_back(64'hA1); exp_q.push_back(64'hA2);
    in_valid = 1; in_data = 64'hA0;
    step(); in_data = 64'hA1;
    step(); in_data = 64'hA2;
    @(negedge clk); check("skid_occ", occupancy, 2);
    check("skid_in_ready", in_ready, 0);
    check("skid_main_data", out_data, 64'hA0);
    step(); step(); step();
    @(negedge clk); check("skid_stall3", stall_cnt, 3);
    out_ready = 1;
    step();
    @(negedge clk); check("skid_stall4", stall_cnt, 4);
    step(); in_valid = 0;
    step();
    @(negedge clk); check("skid_drained_occ", occupancy, 0);

    // Flush while FULL with a beat offered
    out_ready = 0;
    in_valid = 1; in_data = 64'hB0;
    step(); in_data = 64'hB1;
    step();
    @(negedge clk); check("flush_pre_occ", occupancy, 2);
    flush = 1; in_data = 64'hB2;
    step(); flush = 0; in_valid = 0;
    @(negedge clk); check("flush_occ", occupancy, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_data", out_data, 0);
    check("flush_stall_kept", stall_cnt, 5);
    out_ready = 1;
    step(); step();

    // Flush in ONE: the leaving beat is delivered, the arriving one dropped
    out_ready = 0; in_valid = 1; in_data = 64'hB3;
    exp_q.push_back(64'hB3);
    step();
    flush = 1; out_ready = 1; in_data = 64'hB4;
    step(); flush = 0; in_valid = 0;
    @(negedge clk); check("flush_one_occ", occupancy, 0);
    step(); step();

    // Hold for four cycles with both sides eager
    out_ready = 0; in_valid = 1; in_data = 64'hC0;
    exp_q.push_back(64'hC0); exp_q.push_back(64'hC1);
    step();
    hold = 1; out_ready = 1; in_data = 64'hC1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 0);
      check("hold_in_ready", in_ready, 0);
      step();
    end
    @(negedge clk); check("hold_stall", stall_cnt, 9);
    check("hold_occ", occupancy, 1);
    hold = 0;
    step(); in_valid = 0;
    step();
    @(negedge clk); check("hold_drained_occ", occupancy, 0);

    // Reset while FULL discards both entries
    out_ready = 0; in_valid = 1; in_data = 64'hE0;
    step(); in_data = 64'hE1;
    step(); in_valid = 0; reset = 1;
    step(); reset = 0; out_ready = 1;
    @(negedge clk); check("midrst_occ", occupancy, 0);
    check("midrst_stall", stall_cnt, 0);
    check("midrst_out_valid", out_valid, 0);
    step(); step();

    // Saturation on the 4-bit counter
    in_valid2 = 1; in_data2 = 8'h01;
    step(); in_data2 = 8'h02;
    step(); in_data2 = 8'h03;
    for (int i = 0; i < 14; i++) step();
    @(negedge clk); check("sat_stall14", stall_cnt2, 14);
    check("sat_main_data", out_data2, 8'h01);
    for (int i = 0; i < 6; i++) step();
    @(negedge clk); check("sat_stall15", stall_cnt2, 15);
    step();
    @(negedge clk); check("sat_stall_stays", stall_cnt2, 15);

    // Drain, then ZERO_ON_EMPTY = 0 keeps the last main value
    in_valid2 = 0; out_ready2 = 1;
    step(); step();
    out_ready2 = 0; in_valid2 = 1; in_data2 = 8'hD5;
    step(); in_valid2 = 0; out_ready2 = 1;
    step();
    @(negedge clk); check("noz_out_valid", out_valid2, 0);
    check("noz_out_data", out_data2, 8'hD5);
    check("noz_occ", occupancy2, 0);

    step(); step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed fetch/decode stage register.
- Generic pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer (main + skid), so upstream ready never depends combinationally on downstream ready.
- Provides flush (bubble), hold (freeze), zero-on-empty bubbles and a saturating upstream-stall counter.
- Instantiated between any two pipeline stages (F/D, D/E, E/M, M/W) in place of per-stage hand-written registers.

Parameters:
DATA_W, 64, payload width in bits
ZERO_ON_EMPTY, 1, 1 = out_data driven to 0 when no valid entry; 0 = out_data holds the last main-entry value
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all entries this cycle
hold  in  1  freeze stage: no accept, no emit, state unchanged
in_valid  in  1  upstream has a beat
in_ready  out  1  stage can accept a beat
in_data  in  DATA_W  upstream payload
out_valid  out  1  stage presents a beat
out_ready  in  1  downstream accepts the beat
out_data  out  DATA_W  payload of the main entry
occupancy  out  2  number of held entries (0..2)
stall_cnt  out  CNT_W  saturating count of upstream-stall cycles

Behaviour:
- Storage: main_q and skid_q (DATA_W each). State: EMPTY, ONE, FULL; occupancy = 0/1/2 respectively.
- in_ready = !hold && state != FULL. Comes from registered state only; never from out_ready.
- out_valid = !hold && state != EMPTY.
- in_fire = in_valid && in_ready.
- out_fire = out_valid && out_ready.
- out_data = main_q when state != EMPTY. When EMPTY: 0 if ZERO_ON_EMPTY, else main_q.
- Priority per rising edge: reset > flush > hold > normal transfer.
- Reset:
  - state = EMPTY; main_q = skid_q = 0; stall_cnt = 0.
  - Outputs after reset: out_valid 0, in_ready 1, out_data 0, occupancy 0.
  - Reset mid-transfer discards both entries; no beat is emitted afterwards.
- Flush:
  - state = EMPTY; main_q = skid_q = 0.
  - A beat with in_fire in the flush cycle is dropped.
  - A beat with out_fire in the flush cycle counts as delivered downstream; the stage does not re-emit it.
  - stall_cnt is not cleared.
- Hold (flush = 0): all registers keep their values. Combinationally, in_ready = out_valid = 0.
- Normal transfer, EMPTY:
  - in_fire: main_q <= in_data, go to ONE.
  - No in_fire: stay EMPTY.
- Normal transfer, ONE:
  - in_fire and out_fire: main_q <= in_data, stay ONE (full throughput, 1 beat/cycle).
  - in_fire only: skid_q <= in_data, go to FULL.
  - out_fire only: go to EMPTY.
  - Neither: stay ONE.
- Normal transfer, FULL (in_ready = 0):
  - out_fire: main_q <= skid_q, go to ONE.
  - No out_fire: stay FULL.
- Latency: a beat accepted in cycle N is presented in cycle N+1 when the stage was EMPTY (or ONE with out_fire in N). Beats leave strictly in FIFO order.
- stall_cnt:
  - Increments by 1 on every edge where in_valid && !in_ready, not in reset. This includes hold cycles.
  - Saturates at 2^CNT_W-1; no wrap.
- Data held in skid_q while not FULL is don't-care internally, but it is never presented on out_data.
- in_data is sampled only on in_fire; X on in_data while in_valid = 0 must not propagate.

Test Plan:
- Reset then stream: reset 1 cycle; in_valid = 1 with data 0x10,0x11,0x12 on consecutive cycles; out_ready = 1.
  -> out_valid rises 1 cycle after the first accept; out_data = 0x10,0x11,0x12 back-to-back; in_ready stays 1; occupancy stays 1.
- Backpressure/skid: stage holds 0xA0; out_ready = 0 while 0xA1 is offered.
  -> 0xA1 accepted, occupancy = 2, in_ready = 0.
  -> With 0xA2 offered 3 more cycles, stall_cnt = 3.
  -> out_ready = 1 gives 0xA0 then 0xA1, then 0xA2 is accepted.
- Flush with simultaneous input: FULL (0xB0,0xB1), flush = 1 and in_valid = 1 with 0xB2 in the same cycle.
  -> Next cycle occupancy 0, out_valid 0, out_data 0 (ZERO_ON_EMPTY = 1); 0xB2 never appears.
- Hold: ONE with 0xC0, hold = 1 for 4 cycles with out_ready = 1 and in_valid = 1 (0xC1).
  -> out_valid = 0 and in_ready = 0 throughout; stall_cnt += 4.
  -> After hold drops: 0xC0 emitted, then 0xC1.
- Saturation: CNT_W = 4; in_valid = 1 held against FULL for 20 cycles.
  -> stall_cnt = 15 and stays 15.
- ZERO_ON_EMPTY = 0: after 0xD5 is drained to EMPTY.
  -> out_valid = 0, out_data = 0xD5.
